// File: rtl/schmitt_trigger_mc.sv
// Multi-channel hysteresis comparator: per-channel dwell-qualified Schmitt trigger
// with rise/fall pulses and a saturating rise-to-rise period counter.

module stm_ch #(
   parameter int WD = 14,
   parameter int DW = 8,
   parameter int PW = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 smp_en,
   input  logic                 run_en,
   input  logic signed [WD-1:0] d,
   input  logic signed [WD-1:0] th_hi,
   input  logic signed [WD-1:0] th_lo,
   input  logic [DW-1:0]        n,
   output logic                 q,
   output logic                 rise,
   output logic                 fall,
   output logic [PW-1:0]        period,
   output logic                 period_valid
);

   typedef enum logic [1:0] {S_LOW, S_ARM_HI, S_HIGH, S_ARM_LO} st_t;

   st_t           st_q, st_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic          rise_d, fall_d;
   logic [PW-1:0] pcnt_q;
   logic          first_q;

   logic          hi_x, lo_x, arm_done;
   logic [DW:0]   cnt_inc;

   assign hi_x     = d > th_hi;
   assign lo_x     = d < th_lo;
   assign cnt_inc  = {1'b0, cnt_q} + (DW+1)'(1);
   // >= rather than == so a dwell lowered mid-arming confirms on the next sample
   assign arm_done = cnt_inc >= {1'b0, n};
   assign q        = (st_q == S_HIGH) || (st_q == S_ARM_LO);

   always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (run_en) begin
         case (st_q)
            S_LOW: if (hi_x) begin
               if (n == DW'(1)) begin
                  st_d   = S_HIGH;
                  cnt_d  = '0;
                  rise_d = 1'b1;
               end else begin
                  st_d  = S_ARM_HI;
                  cnt_d = DW'(1);
               end
            end
            S_ARM_HI: if (hi_x) begin
               if (arm_done) begin
                  st_d   = S_HIGH;
                  cnt_d  = '0;
                  rise_d = 1'b1;
               end else begin
                  cnt_d = cnt_inc[DW-1:0];
               end
            end else begin
               st_d  = S_LOW;
               cnt_d = '0;
            end
            S_HIGH: if (lo_x) begin
               if (n == DW'(1)) begin
                  st_d   = S_LOW;
                  cnt_d  = '0;
                  fall_d = 1'b1;
               end else begin
                  st_d  = S_ARM_LO;
                  cnt_d = DW'(1);
               end
            end
            S_ARM_LO: if (lo_x) begin
               if (arm_done) begin
                  st_d   = S_LOW;
                  cnt_d  = '0;
                  fall_d = 1'b1;
               end else begin
                  cnt_d = cnt_inc[DW-1:0];
               end
            end else begin
               st_d  = S_HIGH;
               cnt_d = '0;
            end
            default: begin
               st_d  = S_LOW;
               cnt_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q  <= S_LOW;
         cnt_q <= '0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
         rise  <= rise_d;
         fall  <= fall_d;
      end
   end

   // Period counter keeps running even while thresholds are misconfigured
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt_q       <= '0;
         first_q      <= 1'b0;
         period       <= '0;
         period_valid <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         if (smp_en) begin
            if (rise_d) begin
               if (first_q) begin
                  period       <= pcnt_q;
                  period_valid <= 1'b1;
               end
               pcnt_q  <= PW'(1);
               first_q <= 1'b1;
            end else if (pcnt_q != '1) begin
               pcnt_q <= pcnt_q + PW'(1);
            end
         end
      end
   end

endmodule

module schmitt_trigger_mc #(
   parameter int WD  = 14,
   parameter int NCH = 4,
   parameter int DW  = 8,
   parameter int PW  = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  din_valid,
   input  logic [NCH*WD-1:0]     din,
   input  logic signed [WD-1:0]  th_hi,
   input  logic signed [WD-1:0]  th_lo,
   input  logic [DW-1:0]         dwell,
   output logic [NCH-1:0]        q,
   output logic [NCH-1:0]        rise,
   output logic [NCH-1:0]        fall,
   output logic [NCH*PW-1:0]     period,
   output logic [NCH-1:0]        period_valid,
   output logic                  cfg_err
);

   logic [DW-1:0] n_eff;

   assign n_eff = (dwell == '0) ? DW'(1) : dwell;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cfg_err <= 1'b0;
      else     cfg_err <= th_lo > th_hi;
   end

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      stm_ch #(.WD(WD), .DW(DW), .PW(PW)) u_ch (
         .clk          (clk),
         .rst          (rst),
         .smp_en       (din_valid),
         .run_en       (din_valid & ~cfg_err),
         .d            (din[g*WD +: WD]),
         .th_hi        (th_hi),
         .th_lo        (th_lo),
         .n            (n_eff),
         .q            (q[g]),
         .rise         (rise[g]),
         .fall         (fall[g]),
         .period       (period[g*PW +: PW]),
         .period_valid (period_valid[g])
      );
   end

endmodule

// File: tb/tb_schmitt_trigger_mc.sv
// Bench for schmitt_trigger_mc: directed scenarios plus random traffic, all
// outputs compared every cycle against a level/run-length reference model.

module tb_schmitt_trigger_mc;

   localparam int WD   = 14;
   localparam int NCH  = 4;
   localparam int DW   = 8;
   localparam int PW   = 6;
   localparam int MAXP = (1 << PW) - 1;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 din_valid;
   logic [NCH*WD-1:0]    din;
   logic signed [WD-1:0] th_hi, th_lo;
   logic [DW-1:0]        dwell;
   logic [NCH-1:0]       q, rise, fall, period_valid;
   logic [NCH*PW-1:0]    period;
   logic                 cfg_err;

   schmitt_trigger_mc #(.WD(WD), .NCH(NCH), .DW(DW), .PW(PW)) dut (
      .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
      .th_hi(th_hi), .th_lo(th_lo), .dwell(dwell),
      .q(q), .rise(rise), .fall(fall), .period(period),
      .period_valid(period_valid), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;

   // Reference: a level, a count of consecutive crossing samples, period state
   int m_lvl[NCH], m_run[NCH], m_first[NCH], m_pcnt[NCH], m_period[NCH];
   int m_rise[NCH], m_fall[NCH], m_pv[NCH];
   int m_cfg;
   int cur[NCH];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NCH; k++) begin
         m_lvl[k] = 0; m_run[k] = 0; m_first[k] = 0; m_pcnt[k] = 0;
         m_period[k] = 0; m_rise[k] = 0; m_fall[k] = 0; m_pv[k] = 0;
      end
      m_cfg = 0;
   endtask

   task automatic model_step();
      logic signed [WD-1:0] dk;
      int dv, hi, lo, n, rose;
      hi = int'(th_hi);
      lo = int'(th_lo);
      n  = (dwell == '0) ? 1 : int'(dwell);
      for (int k = 0; k < NCH; k++) begin
         m_rise[k] = 0; m_fall[k] = 0; m_pv[k] = 0;
         if (din_valid) begin
            dk = din[k*WD +: WD];
            dv = int'(dk);
            rose = 0;
            if (m_cfg == 0) begin
               if (m_lvl[k] == 0) begin
                  if (dv > hi) begin
                     m_run[k]++;
                     if (m_run[k] >= n) begin m_lvl[k] = 1; m_run[k] = 0; rose = 1; m_rise[k] = 1; end
                  end else m_run[k] = 0;
               end else begin
                  if (dv < lo) begin
                     m_run[k]++;
                     if (m_run[k] >= n) begin m_lvl[k] = 0; m_run[k] = 0; m_fall[k] = 1; end
                  end else m_run[k] = 0;
               end
            end
            if (rose != 0) begin
               if (m_first[k] != 0) begin m_period[k] = m_pcnt[k]; m_pv[k] = 1; end
               m_pcnt[k] = 1;
               m_first[k] = 1;
            end else if (m_pcnt[k] < MAXP) begin
               m_pcnt[k]++;
            end
         end
      end
      m_cfg = (lo > hi) ? 1 : 0;
   endtask

   task automatic check_all();
      logic [NCH-1:0]    eq, er, ef, epv;
      logic [NCH*PW-1:0] ep;
      for (int k = 0; k < NCH; k++) begin
         eq[k]  = (m_lvl[k] != 0);
         er[k]  = (m_rise[k] != 0);
         ef[k]  = (m_fall[k] != 0);
         epv[k] = (m_pv[k] != 0);
         ep[k*PW +: PW] = PW'(m_period[k]);
      end
      chk("q", 64'(q), 64'(eq));
      chk("rise", 64'(rise), 64'(er));
      chk("fall", 64'(fall), 64'(ef));
      chk("period_valid", 64'(period_valid), 64'(epv));
      chk("period", 64'(period), 64'(ep));
      chk("cfg_err", 64'(cfg_err), 64'(m_cfg != 0));
   endtask

   task automatic cyc(input bit v);
      for (int k = 0; k < NCH; k++)
         din[k*WD +: WD] = v ? WD'(cur[k]) : WD'($urandom);
      din_valid = v;
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic smp(input int k, input int val);
      cur[k] = val;
      cyc(1'b1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      #2;
      rst = 1'b0;
   endtask

   initial begin
      int vals[6];
      int pvn, h;
      rst = 1'b1; din_valid = 1'b0; din = '0;
      th_hi = 14'sd100; th_lo = -14'sd100; dwell = '0;
      for (int k = 0; k < NCH; k++) cur[k] = 0;
      model_reset();
      do_reset();
      chk("reset_q", 64'(q), 64'(0));

      // 1: basic hysteresis, dwell 0
      smp(0, -200); chk("t1_q_lo", 64'(q[0]), 64'(0));
      smp(0, 150);  chk("t1_q_up", 64'(q[0]), 64'(1)); chk("t1_rise", 64'(rise[0]), 64'(1));
      smp(0, 50);   chk("t1_hold", 64'(q[0]), 64'(1)); chk("t1_rise_1clk", 64'(rise[0]), 64'(0));
      smp(0, -150); chk("t1_fall", 64'(fall[0]), 64'(1)); chk("t1_q_dn", 64'(q[0]), 64'(0));
      chk("t1_others", 64'(q[3:1]), 64'(0));

      // 2: dwell 3, a sub-threshold sample restarts arming
      vals = '{150, 150, 90, 150, 150, 150};
      dwell = 8'd3;
      for (int i = 0; i < 6; i++) begin
         smp(1, vals[i]);
         if (i < 5) chk("t2_norise", 64'(rise[1]), 64'(0));
      end
      chk("t2_rise", 64'(rise[1]), 64'(1));
      dwell = '0;
      smp(1, -150); chk("t2_back_low", 64'(fall[1]), 64'(1));

      // 4: same sequence with 4 invalid cycles between samples
      dwell = 8'd3;
      for (int i = 0; i < 6; i++) begin
         repeat (4) cyc(1'b0);
         smp(1, vals[i]);
         if (i < 5) chk("t4_norise", 64'(q[1]), 64'(0));
      end
      chk("t4_rise", 64'(rise[1]), 64'(1));
      dwell = '0;
      smp(1, -150);

      // 3: square wave period 10 on ch2
      pvn = 0;
      for (int p = 0; p < 3; p++)
         for (int i = 0; i < 10; i++) begin
            smp(2, (i < 5) ? 500 : -500);
            if (period_valid[2]) begin
               pvn++;
               chk("t3_period", 64'(period[2*PW +: PW]), 64'(10));
            end
         end
      chk("t3_pv_count", 64'(pvn), 64'(2));

      // 5: inverted thresholds freeze tracking
      th_hi = 14'sd0; th_lo = 14'sd50;
      cyc(1'b0);
      chk("t5_cfg_err", 64'(cfg_err), 64'(1));
      smp(0, 1000); smp(0, -1000); smp(0, 1000);
      chk("t5_frozen_q", 64'(q[0]), 64'(0));
      chk("t5_no_rise", 64'(rise[0]), 64'(0));
      th_lo = -14'sd50;
      cyc(1'b0);
      chk("t5_cfg_clr", 64'(cfg_err), 64'(0));
      smp(0, 1000);  chk("t5_resume", 64'(q[0]), 64'(1));
      smp(0, -1000); chk("t5_fall", 64'(fall[0]), 64'(1));
      th_hi = 14'sd100; th_lo = -14'sd100;

      // 6: async reset mid-arming
      dwell = 8'd5;
      repeat (3) smp(3, 500);
      chk("t6_arming", 64'(q[3]), 64'(0));
      do_reset();
      chk("t6_rst_q", 64'(q), 64'(0));
      chk("t6_rst_period", 64'(period), 64'(0));
      for (int i = 0; i < 4; i++) begin
         smp(3, 500);
         chk("t6_rearm", 64'(q[3]), 64'(0));
      end
      smp(3, 500);
      chk("t6_rise", 64'(rise[3]), 64'(1));

      // period saturation at 2^PW-1
      dwell = '0;
      smp(0, 500);
      repeat (71) smp(0, -500);
      smp(0, 500);
      chk("sat_pv", 64'(period_valid[0]), 64'(1));
      chk("sat_period", 64'(period[0 +: PW]), 64'(MAXP));

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 49) == 0) begin
            h = int'($urandom_range(0, 200)) - 100;
            th_hi = WD'(h);
            h = h - int'($urandom_range(0, 100));
            if ($urandom_range(0, 3) == 0) h = h + 120;
            th_lo = WD'(h);
         end
         if ($urandom_range(0, 19) == 0) dwell = DW'($urandom_range(0, 4));
         for (int k = 0; k < NCH; k++)
            if ($urandom_range(0, 2) == 0) cur[k] = int'($urandom_range(0, 500)) - 250;
         cyc($urandom_range(0, 3) != 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
